piso_serializer: RTL and testbench

Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clk on `sout`, framed by `sout_valid` and `sout_first`. It is the driving end of the lab's serial shift chain: its `sout` and `sout_valid` feed a serial-in shift register or deserializer clocked by the same `clk`. That downstream block samples on the same posedge.

---
 rtl/piso_serializer.sv | 87 ++++++++
 tb/tb_piso_serializer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per clk, framed by first/last markers.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;

  // Handshake: a word transfers on any posedge where load_valid && load_ready;
  // load_ready comes from registered state only, and load_data is sampled
  // solely on that edge, so the upstream may change it freely otherwise.
  assign load_ready = (state_q == IDLE) || (cnt_q == CNT_LAST);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != CNT_LAST) begin
          shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                              : {1'b0, shreg_q[WIDTH-1:1]};
          cnt_d   = cnt_q + 1'b1;
        end else if (accept) begin
          // Reload on the last bit so consecutive words stream without a gap.
          shreg_d = load_data;
          cnt_d   = '0;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sout_valid = (state_q == SHIFT);
  assign sout       = sout_valid & (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
  assign sout_first = sout_valid && (cnt_q == '0);
  assign sout_last  = sout_valid && (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance
// driven from a vector table, plus reset and mid-word abort sequences.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       m_lv, m_rdy, m_sout, m_v, m_f, m_l;
  logic [7:0] m_ld;
  logic       l_lv, l_rdy, l_sout, l_v, l_f, l_l;
  logic [7:0] l_ld;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .load_valid(m_lv), .load_data(m_ld),
    .load_ready(m_rdy), .sout(m_sout), .sout_valid(m_v),
    .sout_first(m_f), .sout_last(m_l)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .load_valid(l_lv), .load_data(l_ld),
    .load_ready(l_rdy), .sout(l_sout), .sout_valid(l_v),
    .sout_first(l_f), .sout_last(l_l)
  );

  int total = 0;
  int bad   = 0;

  // exp packs {load_ready, sout_valid, sout, sout_first, sout_last}
  typedef struct {
    bit         lsb;
    logic       lv;
    logic [7:0] ld;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit lsb, logic lv, logic [7:0] ld, logic [4:0] exp);
    vec_t v;
    v.lsb = lsb;
    v.lv  = lv;
    v.ld  = ld;
    v.exp = exp;
    vecs.push_back(v);
  endfunction

  function automatic logic [4:0] obs(bit lsb);
    if (lsb) return {l_rdy, l_v, l_sout, l_f, l_l};
    return {m_rdy, m_v, m_sout, m_f, m_l};
  endfunction

  task automatic chk(string nm, int idx, logic [4:0] act, logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %b want %b (ready,valid,sout,first,last)",
               nm, idx, act, exp);
    end
  endtask

  logic [7:0] w;

  initial begin
    // MSB-first 8'hA5
    add(0, 1, 8'hA5, 5'b10000);
    add(0, 0, 8'h00, 5'b01110);
    add(0, 0, 8'h00, 5'b01000);
    add(0, 0, 8'h00, 5'b01100);
    add(0, 0, 8'h00, 5'b01000);
    add(0, 0, 8'h00, 5'b01000);
    add(0, 0, 8'h00, 5'b01100);
    add(0, 0, 8'h00, 5'b01000);
    add(0, 0, 8'h00, 5'b11101);
    add(0, 0, 8'h00, 5'b10000);
    // LSB-first 8'hA5 (bit 0 up: 1,0,1,0,0,1,0,1)
    add(1, 1, 8'hA5, 5'b10000);
    add(1, 0, 8'h00, 5'b01110);
    add(1, 0, 8'h00, 5'b01000);
    add(1, 0, 8'h00, 5'b01100);
    add(1, 0, 8'h00, 5'b01000);
    add(1, 0, 8'h00, 5'b01000);
    add(1, 0, 8'h00, 5'b01100);
    add(1, 0, 8'h00, 5'b01000);
    add(1, 0, 8'h00, 5'b11101);
    add(1, 0, 8'h00, 5'b10000);
    // LSB-first 8'h1E (bit 0 up: 0,1,1,1,1,0,0,0) tells the orders apart
    add(1, 1, 8'h1E, 5'b10000);
    add(1, 0, 8'h00, 5'b01010);
    add(1, 0, 8'h00, 5'b01100);
    add(1, 0, 8'h00, 5'b01100);
    add(1, 0, 8'h00, 5'b01100);
    add(1, 0, 8'h00, 5'b01100);
    add(1, 0, 8'h00, 5'b01000);
    add(1, 0, 8'h00, 5'b01000);
    add(1, 0, 8'h00, 5'b11001);
    add(1, 0, 8'h00, 5'b10000);
    // Back-to-back 8'hFF then 8'h00, load_valid held high through the reload
    add(0, 1, 8'hFF, 5'b10000);
    add(0, 1, 8'h00, 5'b01110);
    for (int i = 0; i < 6; i++) add(0, 1, 8'h00, 5'b01100);
    add(0, 1, 8'h00, 5'b11101);
    add(0, 0, 8'h00, 5'b01010);
    for (int i = 0; i < 6; i++) add(0, 0, 8'h00, 5'b01000);
    add(0, 0, 8'h00, 5'b11001);
    add(0, 0, 8'h00, 5'b10000);
    // 8'h96 (1,0,0,1,0,1,1,0) with 8'h3C offered during bits 2..6
    add(0, 1, 8'h96, 5'b10000);
    add(0, 0, 8'h00, 5'b01110);
    add(0, 1, 8'h3C, 5'b01000);
    add(0, 1, 8'h3C, 5'b01000);
    add(0, 1, 8'h3C, 5'b01100);
    add(0, 1, 8'h3C, 5'b01000);
    add(0, 1, 8'h3C, 5'b01100);
    add(0, 0, 8'h00, 5'b01100);
    add(0, 0, 8'h00, 5'b11001);
    add(0, 0, 8'h00, 5'b10000);

    // Reset held 3 cycles with load_valid high: nothing may be accepted
    rst_n = 1'b0;
    m_lv = 1'b1; m_ld = 8'hA5;
    l_lv = 1'b1; l_ld = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_msb", i, obs(0), 5'b10000);
      chk("rst_lsb", i, obs(1), 5'b10000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // First posedge after release accepts the pending word
    w = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      m_lv = 1'b0; l_lv = 1'b0;
      #1;
      chk("post_rst", k, obs(0), {k == 7, 1'b1, w[7-k], k == 0, k == 7});
      if (k == 0) chk("post_rst_lsb", k, obs(1), 5'b01110);
    end
    @(negedge clk); #1;
    chk("post_rst_idle", 0, obs(0), 5'b10000);
    chk("post_rst_idle_lsb", 0, obs(1), 5'b10000);

    // Table-driven vectors
    foreach (vecs[i]) begin
      @(negedge clk);
      m_lv = 1'b0; m_ld = 8'h00;
      l_lv = 1'b0; l_ld = 8'h00;
      if (vecs[i].lsb) begin
        l_lv = vecs[i].lv; l_ld = vecs[i].ld;
      end else begin
        m_lv = vecs[i].lv; m_ld = vecs[i].ld;
      end
      #1;
      chk(vecs[i].lsb ? "vec_lsb" : "vec_msb", i, obs(vecs[i].lsb), vecs[i].exp);
    end

    // Mid-word reset on the 4th bit of 8'hF0, then a clean 8'h81
    @(negedge clk);
    m_lv = 1'b1; m_ld = 8'hF0;
    #1;
    chk("abort_idle", 0, obs(0), 5'b10000);
    w = 8'hF0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m_lv = 1'b0;
      #1;
      chk("abort_bits", k, obs(0), {1'b0, 1'b1, w[7-k], k == 0, 1'b0});
    end
    #1 rst_n = 1'b0;
    #1;
    chk("abort_async", 0, obs(0), 5'b10000);
    @(negedge clk); #1;
    chk("abort_held", 0, obs(0), 5'b10000);
    rst_n = 1'b1;
    m_lv = 1'b1; m_ld = 8'h81;
    w = 8'h81;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      m_lv = 1'b0; m_ld = 8'h00;
      #1;
      chk("after_abort", k, obs(0), {k == 7, 1'b1, w[7-k], k == 0, k == 7});
    end
    @(negedge clk); #1;
    chk("after_abort_idle", 0, obs(0), 5'b10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
